// File: rtl/dff_pkg.sv
// Shared constants for the dff_eight_bit register family: default width and
// the all-zero / all-one patterns used as default reset and set values.
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH = 8;

  localparam logic [DFF_DEFAULT_WIDTH-1:0] DFF_ALL_ZERO = {DFF_DEFAULT_WIDTH{1'b0}};
  localparam logic [DFF_DEFAULT_WIDTH-1:0] DFF_ALL_ONE  = {DFF_DEFAULT_WIDTH{1'b1}};

endpackage

// File: rtl/dff_bit.sv
// Single register bit with asynchronous clear and preset (clear wins) and a
// load enable; the forced value is held after release until the next capture.
module dff_bit #(
  parameter bit RST_VAL = 1'b0,
  parameter bit SET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic r_q;
  logic w_set_eff;

  // Masking set with Rst gives a rising edge when Rst drops while set is still
  // high, so the bit moves to SET_VAL without waiting for a clock.
  assign w_set_eff = i_set & ~i_rst;

  always_ff @(posedge i_clk or posedge i_rst or posedge w_set_eff) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (w_set_eff) begin
      r_q <= SET_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/dff_eight_bit.sv
// Parallel data register: Q <= D on each rising Clk, async clear Rst > async preset set.
// Optional load enable port "en" when DFF_EIGHT_BIT_LOAD_EN is defined.
module dff_eight_bit
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_ALL_ZERO[0]}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{DFF_ALL_ONE[0]}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             set,
`ifdef DFF_EIGHT_BIT_LOAD_EN
  input  logic             en,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  logic w_en;

`ifdef DFF_EIGHT_BIT_LOAD_EN
  assign w_en = en;
`else
  assign w_en = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .RST_VAL (RST_VAL[i]),
      .SET_VAL (SET_VAL[i])
    ) u_bit (
      .i_clk (Clk),
      .i_rst (Rst),
      .i_set (set),
      .i_en  (w_en),
      .i_d   (D[i]),
      .o_q   (Q[i])
    );
  end

endmodule

// File: tb/tb_dff_eight_bit.sv
// Self-checking bench for dff_eight_bit: async set/clear, full data sweep,
// priority and release behaviour, and the optional load enable.
module tb_dff_eight_bit;

  localparam int W = 8;

  logic         Clk;
  logic         Rst;
  logic         set;
  logic [W-1:0] D;
  logic [W-1:0] Q;
`ifdef DFF_EIGHT_BIT_LOAD_EN
  logic         en;
`endif

  logic         clk_en;
  int           checks;
  int           errors;
  logic [W-1:0] exp_q[$];

  dff_eight_bit dut (
    .Clk (Clk),
    .Rst (Rst),
    .set (set),
`ifdef DFF_EIGHT_BIT_LOAD_EN
    .en  (en),
`endif
    .D   (D),
    .Q   (Q)
  );

  // clock: idle low until clk_en, then 10 ns period
  initial Clk = 1'b0;
  always #5 if (clk_en) Clk = ~Clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // drive D while Clk is low and queue the value Q must show after the next edge
  task automatic drive(input logic [W-1:0] d, input logic [W-1:0] exp);
    @(negedge Clk);
    D = d;
    exp_q.push_back(exp);
  endtask

  task automatic edge_check(input string tag);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty at %0t", tag, $time);
    end else begin
      check_val(tag, Q, exp_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk_en = 1'b0;
    Rst    = 1'b0;
    set    = 1'b0;
    D      = '0;
`ifdef DFF_EIGHT_BIT_LOAD_EN
    en     = 1'b1;
`endif

    // power-up: async set and clear with the clock idle
    #2 set = 1'b1;
    #1 check_val("pwr_set", Q, 8'hFF);
    #4 set = 1'b0;
    #1 check_val("pwr_set_hold", Q, 8'hFF);
    Rst = 1'b1;
    #1 check_val("pwr_rst", Q, 8'h00);
    #4 Rst = 1'b0;
    #1 check_val("pwr_rst_hold", Q, 8'h00);

    clk_en = 1'b1;

    // counting sweep 0..255
    for (int i = 0; i < 256; i++) begin
      drive(W'(i), W'(i));
      edge_check("sweep");
    end

    // random data
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] r;
      r = W'($urandom_range(0, 255));
      drive(r, r);
      edge_check("rand");
    end

    // Rst and set together, then staged release
    @(negedge Clk);
    D   = 8'h12;
    Rst = 1'b1;
    set = 1'b1;
    #1 check_val("both_hi", Q, 8'h00);
    exp_q.push_back(8'h00);
    edge_check("both_hi_edge");
    @(negedge Clk);
    Rst = 1'b0;
    #1 check_val("rst_drop_set_hi", Q, 8'hFF);
    exp_q.push_back(8'hFF);
    edge_check("set_hi_edge");
    @(negedge Clk);
    set = 1'b0;
    D   = 8'h34;
    #1 check_val("set_drop_hold", Q, 8'hFF);
    exp_q.push_back(8'h34);
    edge_check("set_release_cap");

    // mid-sweep reset
    drive(8'hA5, 8'hA5);
    edge_check("pre_rst");
    @(negedge Clk);
    #2 Rst = 1'b1;
    D = 8'h3C;
    #1 check_val("mid_rst", Q, 8'h00);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h00);
      edge_check("rst_hold_edge");
    end
    @(negedge Clk);
    Rst = 1'b0;
    #1 check_val("rst_release_hold", Q, 8'h00);
    exp_q.push_back(8'h3C);
    edge_check("rst_release_cap");

`ifdef DFF_EIGHT_BIT_LOAD_EN
    @(negedge Clk);
    en = 1'b0;
    D  = 8'h55;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h3C);
      edge_check("en0_hold");
    end
    @(negedge Clk);
    en = 1'b1;
    exp_q.push_back(8'h55);
    edge_check("en1_load");
    @(negedge Clk);
    en  = 1'b0;
    set = 1'b1;
    #1 check_val("en0_set", Q, 8'hFF);
    @(negedge Clk);
    set = 1'b0;
    en  = 1'b1;
`endif

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
